// File: rtl/vga_plot_arbiter_if.sv
// Bundles the background stream, the rectangle job handshake and the plot stream to the VGA adapter.
// The master drives the background/rectangle inputs; the arbiter is the slave.
interface vga_plot_arbiter_if;
  logic       bg_draw;
  logic [9:0] bg_x;
  logic [9:0] bg_y;
  logic [2:0] bg_colour;

  logic       rect_req;
  logic [7:0] rect_x;
  logic [6:0] rect_y;
  logic [7:0] rect_w;
  logic [6:0] rect_h;
  logic [2:0] rect_colour;
  logic       rect_ack;
  logic       rect_busy;

  logic       vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  modport master (
    output bg_draw, bg_x, bg_y, bg_colour,
    output rect_req, rect_x, rect_y, rect_w, rect_h, rect_colour,
    input  rect_ack, rect_busy,
    input  vga_plot, vga_x, vga_y, vga_colour
  );

  modport slave (
    input  bg_draw, bg_x, bg_y, bg_colour,
    input  rect_req, rect_x, rect_y, rect_w, rect_h, rect_colour,
    output rect_ack, rect_busy,
    output vga_plot, vga_x, vga_y, vga_colour
  );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Merges a re-timed, never-stalled background pixel stream (plot BG_LAT+1 cycles after bg_draw) with
// rectangle fill jobs that only advance on cycles where the background stream and its pipeline are idle.
module vga_plot_arbiter #(
  parameter int BG_LAT = 2,
  parameter int H_RES  = 160,
  parameter int V_RES  = 120
) (
  input logic               clk,
  input logic               resetn,
  vga_plot_arbiter_if.slave bus
);

  localparam logic [9:0] H_LIM10 = 10'(H_RES);
  localparam logic [9:0] V_LIM10 = 10'(V_RES);
  localparam logic [8:0] H_LIM9  = 9'(H_RES);
  localparam logic [7:0] V_LIM8  = 8'(V_RES);

  typedef enum logic {IDLE, RECT_RUN} state_t;

  // Background alignment pipeline
  logic [BG_LAT-1:0] pipe_vld;
  logic [BG_LAT-1:0] pipe_vis;
  logic [7:0]        pipe_x [BG_LAT];
  logic [6:0]        pipe_y [BG_LAT];
  logic              bg_vis;
  logic              bg_quiet;

  // Clip on the full input width so large coordinates cannot alias into the visible area.
  assign bg_vis   = (bus.bg_x < H_LIM10) && (bus.bg_y < V_LIM10);
  assign bg_quiet = !bus.bg_draw && (pipe_vld == '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pipe_vld <= '0;
      pipe_vis <= '0;
    end else begin
      pipe_vld[0] <= bus.bg_draw;
      pipe_vis[0] <= bg_vis;
      for (int i = 1; i < BG_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_vis[i] <= pipe_vis[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    pipe_x[0] <= bus.bg_x[7:0];
    pipe_y[0] <= bus.bg_y[6:0];
    for (int i = 1; i < BG_LAT; i++) begin
      pipe_x[i] <= pipe_x[i-1];
      pipe_y[i] <= pipe_y[i-1];
    end
  end

  // Rectangle engine
  state_t     state, state_n;
  logic [7:0] rx, rw, cx, cx_n;
  logic [6:0] ry, rh, cy, cy_n;
  logic [2:0] rc;
  logic       ack_q, ack_n;
  logic       latch_job;
  logic       rect_issue;
  logic       job_empty;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic       rect_vis;

  assign job_empty = (rw == 8'd0) || (rh == 7'd0);
  assign sum_x     = {1'b0, rx} + {1'b0, cx};
  assign sum_y     = {1'b0, ry} + {1'b0, cy};
  assign rect_vis  = (sum_x < H_LIM9) && (sum_y < V_LIM8);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    ack_n      = 1'b0;
    latch_job  = 1'b0;
    rect_issue = 1'b0;
    cx_n       = cx;
    cy_n       = cy;
    case (state)
      IDLE: begin
        if (bus.rect_req && bg_quiet) begin
          state_n   = RECT_RUN;
          ack_n     = 1'b1;
          latch_job = 1'b1;
          cx_n      = 8'd0;
          cy_n      = 7'd0;
        end
      end
      RECT_RUN: begin
        // An empty job leaves after its ack cycle regardless of background activity.
        if (job_empty) begin
          state_n = IDLE;
        end else if (bg_quiet) begin
          rect_issue = 1'b1;
          if (cx == rw - 8'd1) begin
            cx_n = 8'd0;
            if (cy == rh - 7'd1) begin
              cy_n    = 7'd0;
              state_n = IDLE;
            end else begin
              cy_n = cy + 7'd1;
            end
          end else begin
            cx_n = cx + 8'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output plot register
  logic       plot_q, plot_n;
  logic [7:0] vx_q, vx_n;
  logic [6:0] vy_q, vy_n;
  logic [2:0] vc_q, vc_n;

  always_comb begin
    plot_n = 1'b0;
    vx_n   = vx_q;
    vy_n   = vy_q;
    vc_n   = vc_q;
    if (pipe_vld[BG_LAT-1]) begin
      plot_n = pipe_vis[BG_LAT-1];
      vx_n   = pipe_x[BG_LAT-1];
      vy_n   = pipe_y[BG_LAT-1];
      vc_n   = bus.bg_colour;
    end else if (rect_issue) begin
      plot_n = rect_vis;
      vx_n   = sum_x[7:0];
      vy_n   = sum_y[6:0];
      vc_n   = rc;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ack_q  <= 1'b0;
      cx     <= 8'd0;
      cy     <= 7'd0;
      rx     <= 8'd0;
      ry     <= 7'd0;
      rw     <= 8'd0;
      rh     <= 7'd0;
      rc     <= 3'd0;
      plot_q <= 1'b0;
      vx_q   <= 8'd0;
      vy_q   <= 7'd0;
      vc_q   <= 3'd0;
    end else begin
      ack_q  <= ack_n;
      cx     <= cx_n;
      cy     <= cy_n;
      if (latch_job) begin
        rx <= bus.rect_x;
        ry <= bus.rect_y;
        rw <= bus.rect_w;
        rh <= bus.rect_h;
        rc <= bus.rect_colour;
      end
      plot_q <= plot_n;
      vx_q   <= vx_n;
      vy_q   <= vy_n;
      vc_q   <= vc_n;
    end
  end

  assign bus.rect_ack   = ack_q;
  assign bus.rect_busy  = (state == RECT_RUN);
  assign bus.vga_plot   = plot_q;
  assign bus.vga_x      = vx_q;
  assign bus.vga_y      = vy_q;
  assign bus.vga_colour = vc_q;

endmodule
